dcache_2way: RTL and testbench
==============================

DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning CPU byte-address width.
REQ-002 SHALL have parameter BLOCK_BYTES, default 4, meaning bytes per cache block (power of 2, >=2).
REQ-003 SHALL have parameter SETS, default 4, meaning number of sets (power of 2, >=2); associativity is fixed at 2 ways.
REQ-004 SHALL have ports: CLK  in  1  clock; all state changes occur on its rising edge.
REQ-005 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports C_READ, C_WRITE  in  1 each  CPU read/write request, held by the CPU until C_BUSYWAIT is low.
REQ-007 SHALL have ports C_ADDRESS  in  ADDR_W  byte address; C_WRITEDATA  in  8  store byte; C_READDATA  out  8  load byte; C_BUSYWAIT  out  1  stall.
REQ-008 SHALL have ports mem_read, mem_write  out  1 each; mem_address  out  ADDR_W-log2(BLOCK_BYTES)  block address; mem_writedata  out  8*BLOCK_BYTES; mem_readdata  in  8*BLOCK_BYTES; mem_busywait  in  1.

Function
REQ-009 SHALL split C_ADDRESS into offset (low log2(BLOCK_BYTES) bits), index (next log2(SETS) bits), tag (remaining bits).
REQ-010 SHALL store per way per set: block data, tag, valid bit, dirty bit; and per set one LRU bit naming the least-recently-used way.
REQ-011 SHALL declare a hit when exactly one way of the indexed set is valid with matching tag (combinational).
REQ-012 SHALL drive C_BUSYWAIT = (C_READ xor C_WRITE) and not (state IDLE and hit), combinationally.
REQ-013 SHALL, on read hit, drive C_READDATA combinationally with the byte at offset of the hit way; zero-cycle stall.
REQ-014 SHALL, on write hit, write C_WRITEDATA into the addressed byte, set dirty, at the next rising edge; no memory traffic.
REQ-015 SHALL, on any hit, set the set's LRU bit to the other way at that rising edge.
REQ-016 SHALL, on miss, select victim: first invalid way (way 0 preferred), else the LRU way; victim is latched on leaving IDLE.
REQ-017 SHALL implement FSM states IDLE, MEM_WRITE, MEM_READ, CACHE_UPDATE.
REQ-018 IDLE -> MEM_WRITE on miss with dirty victim; IDLE -> MEM_READ on miss with clean/invalid victim; else stay.
REQ-019 MEM_WRITE: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block; -> MEM_READ at edge where mem_busywait=0.
REQ-020 MEM_READ: mem_read=1, mem_address={tag,index}; -> CACHE_UPDATE at edge where mem_busywait=0; mem_readdata captured at that edge.
REQ-021 CACHE_UPDATE (one cycle): write captured block, tag, valid=1, dirty=0 into victim way; -> IDLE, where the request then hits.
REQ-022 SHALL drive mem_read=mem_write=0 in IDLE and CACHE_UPDATE; mem_address/mem_writedata stable for the whole of MEM_READ/MEM_WRITE.
REQ-023 SHALL treat C_READ and C_WRITE both high as no request: no state change, no memory traffic, C_BUSYWAIT=0.
REQ-024 SHALL complete an in-flight miss sequence even if the CPU request drops; memory is assumed to raise mem_busywait in the same cycle as the request.

Reset
REQ-025 SHALL, while RESET=0, force state IDLE, clear all valid, dirty and LRU bits, drive mem_read=mem_write=0, C_BUSYWAIT=0, C_READDATA=0, mem_address=0, mem_writedata=0.
REQ-026 SHALL, on reset mid-miss, abandon the transfer immediately; dirty data is discarded; data/tag arrays need not be cleared.

Structure
REQ-027 SHALL place FSM state encodings and default parameter values in shared package dcache_pkg.
REQ-028 SHALL use one sub-module dcache_way (tag/valid/dirty/data storage and tag compare for one way), instantiated twice.

Verification (defaults: ADDR_W=8, BLOCK_BYTES=4, SETS=4)
REQ-029 After reset, read 0x00 -> mem_read, mem_address=0x00; memory returns 0x44332211 -> C_READDATA=0x11, C_BUSYWAIT low after CACHE_UPDATE.
REQ-030 Read 0x04 (fill), write 0x05=0xAB -> one-cycle hit, no mem_write/mem_read; read 0x05 -> 0xAB.
REQ-031 Read 0x00 then 0x10 (same set, tags 0,1) -> both fill; re-read 0x00 and 0x10 -> hits, no memory traffic.
REQ-032 Write 0x00=0x5A, read 0x10, read 0x20 -> victim is 0x00's way: mem_write mem_address=0x00 with byte0=0x5A, then mem_read mem_address=0x08.
REQ-033 Assert RESET=0 during MEM_READ -> mem_read=0 immediately; after release, read of same address misses again.
REQ-034 C_READ=C_WRITE=1 at 0x00 -> C_BUSYWAIT=0, no memory traffic, cache contents unchanged.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the two-way data cache.
//   DEF_*   : default parameter values for the cache and its bus interface
//   state_t : miss-handling controller states
package dcache_pkg;

  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_BLOCK_BYTES = 4;
  localparam int unsigned DEF_SETS        = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    MEM_WRITE    = 2'd1,
    MEM_READ     = 2'd2,
    CACHE_UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache.
//   slave  : the cache's view (CPU requests and memory responses in; load data,
//            stall and memory requests out)
//   master : the environment's view (CPU + backing memory)
interface dcache_if import dcache_pkg::*; #(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES
) ();
  localparam int unsigned OFF_W   = $clog2(BLOCK_BYTES);
  localparam int unsigned MADDR_W = ADDR_W - OFF_W;

  logic                     C_READ;
  logic                     C_WRITE;
  logic [ADDR_W-1:0]        C_ADDRESS;
  logic [7:0]               C_WRITEDATA;
  logic [7:0]               C_READDATA;
  logic                     C_BUSYWAIT;

  logic                     mem_read;
  logic                     mem_write;
  logic [MADDR_W-1:0]       mem_address;
  logic [8*BLOCK_BYTES-1:0] mem_writedata;
  logic [8*BLOCK_BYTES-1:0] mem_readdata;
  logic                     mem_busywait;

  modport slave (
    input  C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, mem_readdata, mem_busywait,
    output C_READDATA, C_BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output C_READ, C_WRITE, C_ADDRESS, C_WRITEDATA, mem_readdata, mem_busywait,
    input  C_READDATA, C_BUSYWAIT, mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/dcache_way.sv
// One way of the cache: per-set block data, tag, valid and dirty bits, plus
// the tag compare for the currently indexed set.
//   clk, rst_n          : clock, async active-low reset (clears valid/dirty only)
//   idx, tag            : set being looked at and tag to compare against
//   match               : indexed entry valid with equal tag
//   valid, dirty,
//   tag_out, block      : indexed entry contents
//   byte_we/offset/
//   byte_data           : store one byte into the indexed block, marks it dirty
//   fill_we/fill_tag/
//   fill_block          : replace indexed entry with a clean, valid block
module dcache_way import dcache_pkg::*; #(
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
  localparam int unsigned OFF_W      = $clog2(BLOCK_BYTES),
  localparam int unsigned BLK_W      = 8 * BLOCK_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [TAG_W-1:0] tag,
  output logic             match,
  output logic             valid,
  output logic             dirty,
  output logic [TAG_W-1:0] tag_out,
  output logic [BLK_W-1:0] block,
  input  logic             byte_we,
  input  logic [OFF_W-1:0] offset,
  input  logic [7:0]       byte_data,
  input  logic             fill_we,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [BLK_W-1:0] fill_block
);
  localparam int unsigned SETS = 1 << IDX_W;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (byte_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset: valid bits already mark them meaningless.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_block;
    end else if (byte_we) begin
      data_q[idx][{offset, 3'b000} +: 8] <= byte_data;
    end
  end

  assign valid   = valid_q[idx];
  assign dirty   = dirty_q[idx];
  assign tag_out = tag_q[idx];
  assign block   = data_q[idx];
  assign match   = valid_q[idx] && (tag_q[idx] == tag);
endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative, write-back, write-allocate byte data cache with
// per-set LRU replacement.
//   CLK   : clock
//   RESET : async active-low reset
//   bus   : dcache_if.slave -- CPU request/response and block memory bus
module dcache_2way import dcache_pkg::*; #(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int unsigned SETS        = DEF_SETS
) (
  input  logic    CLK,
  input  logic    RESET,
  dcache_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(BLOCK_BYTES);
  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned BLK_W = 8 * BLOCK_BYTES;

  state_t state, state_nx;

  logic [OFF_W-1:0] a_off;
  logic [IDX_W-1:0] a_idx;
  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] idx;

  logic [IDX_W-1:0] lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             lat_victim;
  logic [BLK_W-1:0] fill_buf;
  logic [SETS-1:0]  lru;

  logic [1:0]       w_match, w_valid, w_dirty, byte_we, fill_we;
  logic [TAG_W-1:0] w_tag   [2];
  logic [BLK_W-1:0] w_block [2];

  logic req, hit, hit_way, idle_hit, victim_sel, victim_dirty;

  logic                   mem_rd, mem_wr;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [BLK_W-1:0]       mem_wdata;

  assign a_off = bus.C_ADDRESS[OFF_W-1:0];
  assign a_idx = bus.C_ADDRESS[OFF_W +: IDX_W];
  assign a_tag = bus.C_ADDRESS[ADDR_W-1 -: TAG_W];

  // During a miss the ways are addressed by the latched index, so the fill
  // and write-back still target the right set if the CPU request goes away.
  assign idx = (state == IDLE) ? a_idx : lat_idx;

  assign req          = bus.C_READ ^ bus.C_WRITE;
  assign hit          = w_match[0] ^ w_match[1];
  assign hit_way      = w_match[1];
  assign idle_hit     = (state == IDLE) && req && hit;
  assign victim_sel   = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : lru[a_idx]);
  assign victim_dirty = w_valid[victim_sel] && w_dirty[victim_sel];

  for (genvar w = 0; w < 2; w++) begin : g_byte_we
    assign byte_we[w] = idle_hit && bus.C_WRITE && (hit_way == w[0]);
  end

  dcache_way #(.TAG_W(TAG_W), .IDX_W(IDX_W), .BLOCK_BYTES(BLOCK_BYTES)) u_way0 (
    .clk(CLK), .rst_n(RESET), .idx(idx), .tag(a_tag),
    .match(w_match[0]), .valid(w_valid[0]), .dirty(w_dirty[0]),
    .tag_out(w_tag[0]), .block(w_block[0]),
    .byte_we(byte_we[0]), .offset(a_off), .byte_data(bus.C_WRITEDATA),
    .fill_we(fill_we[0]), .fill_tag(lat_tag), .fill_block(fill_buf)
  );

  dcache_way #(.TAG_W(TAG_W), .IDX_W(IDX_W), .BLOCK_BYTES(BLOCK_BYTES)) u_way1 (
    .clk(CLK), .rst_n(RESET), .idx(idx), .tag(a_tag),
    .match(w_match[1]), .valid(w_valid[1]), .dirty(w_dirty[1]),
    .tag_out(w_tag[1]), .block(w_block[1]),
    .byte_we(byte_we[1]), .offset(a_off), .byte_data(bus.C_WRITEDATA),
    .fill_we(fill_we[1]), .fill_tag(lat_tag), .fill_block(fill_buf)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      lru        <= '0;
      lat_idx    <= '0;
      lat_tag    <= '0;
      lat_victim <= 1'b0;
      fill_buf   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) begin
        lat_idx    <= a_idx;
        lat_tag    <= a_tag;
        lat_victim <= victim_sel;
      end
      if (state == MEM_READ && !bus.mem_busywait) begin
        fill_buf <= bus.mem_readdata;
      end
      if (idle_hit) begin
        lru[a_idx] <= ~hit_way;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we   = '0;
    unique case (state)
      IDLE: begin
        if (req && !hit) begin
          state_nx = victim_dirty ? MEM_WRITE : MEM_READ;
        end
      end
      MEM_WRITE: begin
        mem_wr    = 1'b1;
        mem_addr  = {w_tag[lat_victim], lat_idx};
        mem_wdata = w_block[lat_victim];
        if (!bus.mem_busywait) begin
          state_nx = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_rd   = 1'b1;
        mem_addr = {lat_tag, lat_idx};
        if (!bus.mem_busywait) begin
          state_nx = CACHE_UPDATE;
        end
      end
      CACHE_UPDATE: begin
        fill_we[lat_victim] = 1'b1;
        state_nx            = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.mem_read      = RESET && mem_rd;
  assign bus.mem_write     = RESET && mem_wr;
  assign bus.mem_address   = RESET ? mem_addr  : '0;
  assign bus.mem_writedata = RESET ? mem_wdata : '0;

  assign bus.C_BUSYWAIT = RESET && req && !((state == IDLE) && hit);
  assign bus.C_READDATA = (RESET && state == IDLE && hit) ?
                          w_block[hit_way][{a_off, 3'b000} +: 8] : 8'h00;
endmodule

// File: tb/tb_dcache_2way.sv
module tb_dcache_2way;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dcache_if #(.ADDR_W(8), .BLOCK_BYTES(4)) bus ();

  dcache_2way #(.ADDR_W(8), .BLOCK_BYTES(4), .SETS(4)) dut (
    .CLK(clk), .RESET(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Backing memory: word-per-block, busy for LAT cycles then accepts.
  logic [31:0] mem [64];
  int lat_cnt = 0;
  assign bus.mem_busywait = (bus.mem_read || bus.mem_write) && (lat_cnt != LAT);
  assign bus.mem_readdata = mem[bus.mem_address];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h44332211 + i * 32'h01010101;
    forever begin
      @(posedge clk);
      if (bus.mem_read || bus.mem_write) begin
        if (lat_cnt == LAT) begin
          lat_cnt <= 0;
          if (bus.mem_write) mem[bus.mem_address] <= bus.mem_writedata;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end else begin
        lat_cnt <= 0;
      end
    end
  end

  // Architectural model: the newest value of every byte the CPU can see.
  logic [7:0]  shadow [256];
  int          rd_cyc = 0, wr_cyc = 0;
  logic [5:0]  last_rd_addr, last_wr_addr;
  logic [31:0] last_wr_data;
  logic        prev_mr = 1'b0, prev_mw = 1'b0;
  logic [5:0]  prev_addr = '0;
  logic [31:0] prev_wd = '0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        // Reset drops any cached dirty data: visible state is memory again.
        for (int i = 0; i < 256; i++) shadow[i] = mem[i >> 2][(i % 4) * 8 +: 8];
        check("rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check("rst_busywait", {31'd0, bus.C_BUSYWAIT}, 32'd0);
        check("rst_readdata", {24'd0, bus.C_READDATA}, 32'd0);
        check("rst_mem_addr", {26'd0, bus.mem_address}, 32'd0);
        check("rst_mem_wdata", bus.mem_writedata, 32'd0);
        prev_mr = 1'b0;
        prev_mw = 1'b0;
      end else begin
        check("mem_rw_exclusive", {31'd0, bus.mem_read && bus.mem_write}, 32'd0);
        if (bus.C_READ && bus.C_WRITE)
          check("both_high_busy", {31'd0, bus.C_BUSYWAIT}, 32'd0);
        if ((bus.C_READ ^ bus.C_WRITE) && !bus.C_BUSYWAIT) begin
          if (bus.C_READ)
            check("load_byte", {24'd0, bus.C_READDATA}, {24'd0, shadow[bus.C_ADDRESS]});
          else
            shadow[bus.C_ADDRESS] = bus.C_WRITEDATA;
        end
        if (bus.mem_read) begin
          rd_cyc++;
          if (!prev_mr) last_rd_addr = bus.mem_address;
          else check("mem_read_addr_stable", {26'd0, bus.mem_address}, {26'd0, prev_addr});
        end
        if (bus.mem_write) begin
          wr_cyc++;
          if (!prev_mw) begin
            last_wr_addr = bus.mem_address;
            last_wr_data = bus.mem_writedata;
          end else begin
            check("mem_write_addr_stable", {26'd0, bus.mem_address}, {26'd0, prev_addr});
            check("mem_write_data_stable", bus.mem_writedata, prev_wd);
          end
          if (!bus.mem_busywait)
            check("writeback_block", bus.mem_writedata,
                  {shadow[{bus.mem_address, 2'd3}], shadow[{bus.mem_address, 2'd2}],
                   shadow[{bus.mem_address, 2'd1}], shadow[{bus.mem_address, 2'd0}]});
        end
        prev_mr   = bus.mem_read;
        prev_mw   = bus.mem_write;
        prev_addr = bus.mem_address;
        prev_wd   = bus.mem_writedata;
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int stalls,
                        output logic [7:0] rdata, output int traffic);
    int t0;
    @(negedge clk);
    #1;
    t0 = rd_cyc + wr_cyc;
    bus.C_READ      = rd;
    bus.C_WRITE     = wr;
    bus.C_ADDRESS   = addr;
    bus.C_WRITEDATA = wd;
    stalls = 0;
    #1;
    while (bus.C_BUSYWAIT === 1'b1 && stalls < 100) begin
      @(negedge clk);
      #2;
      stalls++;
    end
    if (bus.C_BUSYWAIT !== 1'b0) check("access_timeout", 32'd1, 32'd0);
    rdata = bus.C_READDATA;
    @(posedge clk);
    #1;
    bus.C_READ  = 1'b0;
    bus.C_WRITE = 1'b0;
    traffic = rd_cyc + wr_cyc - t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tr, n;
    logic [7:0] rd;
    rst_n           = 1'b0;
    bus.C_READ      = 1'b1;
    bus.C_WRITE     = 1'b0;
    bus.C_ADDRESS   = 8'h00;
    bus.C_WRITEDATA = 8'h00;
    #12;
    check("reset_busy_with_req", {31'd0, bus.C_BUSYWAIT}, 32'd0);
    check("reset_no_mem_read", {31'd0, bus.mem_read}, 32'd0);
    bus.C_READ = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Cold read miss
    access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tr);
    check("cold_rd_data", {24'd0, rd}, 32'h11);
    check("cold_rd_addr", {26'd0, last_rd_addr}, 32'h00);
    check("cold_rd_stalls", st, 5);

    // Fill then write hit then read back
    access(1'b1, 1'b0, 8'h04, 8'h00, st, rd, tr);
    check("fill04_data", {24'd0, rd}, 32'h12);
    access(1'b0, 1'b1, 8'h05, 8'hAB, st, rd, tr);
    check("wr_hit_stalls", st, 0);
    check("wr_hit_traffic", tr, 0);
    access(1'b1, 1'b0, 8'h05, 8'h00, st, rd, tr);
    check("rd_after_wr", {24'd0, rd}, 32'hAB);
    check("rd_after_wr_stalls", st, 0);

    // Two tags in one set coexist
    access(1'b1, 1'b0, 8'h10, 8'h00, st, rd, tr);
    check("fill10_data", {24'd0, rd}, 32'h15);
    access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tr);
    check("rehit00_traffic", tr, 0);
    check("rehit00_data", {24'd0, rd}, 32'h11);
    access(1'b1, 1'b0, 8'h10, 8'h00, st, rd, tr);
    check("rehit10_traffic", tr, 0);

    // Dirty LRU victim is written back before the refill
    access(1'b0, 1'b1, 8'h00, 8'h5A, st, rd, tr);
    access(1'b1, 1'b0, 8'h10, 8'h00, st, rd, tr);
    check("hit10_traffic", tr, 0);
    access(1'b1, 1'b0, 8'h20, 8'h00, st, rd, tr);
    check("evict_wb_addr", {26'd0, last_wr_addr}, 32'h00);
    check("evict_wb_data", last_wr_data, 32'h4433225A);
    check("evict_rd_addr", {26'd0, last_rd_addr}, 32'h08);
    check("evict_stalls", st, 8);
    check("evict_rd_data", {24'd0, rd}, 32'h19);

    // Request withdrawn mid-miss: fill still completes
    @(negedge clk);
    #1;
    bus.C_READ    = 1'b1;
    bus.C_ADDRESS = 8'h08;
    @(negedge clk);
    #1;
    bus.C_READ = 1'b0;
    repeat (10) @(negedge clk);
    access(1'b1, 1'b0, 8'h08, 8'h00, st, rd, tr);
    check("dropped_req_filled", tr, 0);
    check("dropped_req_data", {24'd0, rd}, 32'h13);

    // Reset during MEM_READ
    @(negedge clk);
    #1;
    bus.C_READ    = 1'b1;
    bus.C_ADDRESS = 8'h30;
    n = 0;
    #1;
    while (bus.mem_read !== 1'b1 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    check("saw_mem_read", {31'd0, bus.mem_read}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmiss_rst_mem_read", {31'd0, bus.mem_read}, 32'd0);
    check("midmiss_rst_busy", {31'd0, bus.C_BUSYWAIT}, 32'd0);
    bus.C_READ = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    access(1'b1, 1'b0, 8'h30, 8'h00, st, rd, tr);
    check("post_rst_30_misses", {31'd0, tr > 0}, 32'd1);
    check("post_rst_30_data", {24'd0, rd}, 32'h1D);
    access(1'b1, 1'b0, 8'h05, 8'h00, st, rd, tr);
    check("dirty_discarded", {24'd0, rd}, 32'h23);
    access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tr);
    check("post_rst_00_misses", {31'd0, tr > 0}, 32'd1);
    check("wb_survived", {24'd0, rd}, 32'h5A);

    // Read and write together: ignored
    @(negedge clk);
    #1;
    n = rd_cyc + wr_cyc;
    bus.C_READ      = 1'b1;
    bus.C_WRITE     = 1'b1;
    bus.C_ADDRESS   = 8'h00;
    bus.C_WRITEDATA = 8'hFF;
    #1;
    check("both_busy_low", {31'd0, bus.C_BUSYWAIT}, 32'd0);
    repeat (3) @(negedge clk);
    #4;
    check("both_no_traffic", rd_cyc + wr_cyc - n, 0);
    bus.C_READ  = 1'b0;
    bus.C_WRITE = 1'b0;
    access(1'b1, 1'b0, 8'h00, 8'h00, st, rd, tr);
    check("both_unchanged", {24'd0, rd}, 32'h5A);
    check("both_still_hit", tr, 0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
